// File: rtl/sub4u_serial_chk.sv
// Bit-serial unsigned subtractor with a handshake on each side.
// The result is re-added to b and compared with a to flag corruption.
module sub4u_serial_chk #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         inj_fault,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] diff,
  output logic         borrow,
  output logic         chk_err
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SUB,
    CHECK,
    DONE
  } state_t;

  state_t         state;
  logic [W-1:0]   ra;
  logic [W-1:0]   rb;
  logic [W-1:0]   acc;
  logic           br;
  logic [CW-1:0]  cnt;
  logic           ai;
  logic           bi;
  logic [W:0]     sum;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  assign ai  = ra[cnt];
  assign bi  = rb[cnt];
  assign sum = {1'b0, acc} + {1'b0, rb};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ra      <= '0;
      rb      <= '0;
      acc     <= '0;
      br      <= 1'b0;
      cnt     <= '0;
      diff    <= '0;
      borrow  <= 1'b0;
      chk_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            ra    <= a;
            rb    <= b;
            acc   <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            state <= SUB;
          end
        end
        SUB: begin
          // fault flips only the stored bit, never the borrow chain
          acc[cnt] <= ai ^ bi ^ br ^ inj_fault;
          br       <= (~ai & bi) | (~(ai ^ bi) & br);
          if (cnt == CW'(W - 1)) begin
            state <= CHECK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CHECK: begin
          diff    <= acc;
          borrow  <= br;
          chk_err <= (sum != {br, ra});
          state   <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sub4u_serial_chk.sv
// Directed and randomized bench for sub4u_serial_chk.
// Expected results come from plain modular arithmetic on the operands.
module tb_sub4u_serial_chk;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         inj_fault;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow;
  logic         chk_err;

  int n_chk  = 0;
  int n_fail = 0;

  sub4u_serial_chk #(.W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .inj_fault(inj_fault),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .borrow   (borrow),
    .chk_err  (chk_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one transaction; fm marks SUB edges with inj_fault high
  task automatic run(input logic [W-1:0] ta, input logic [W-1:0] tb,
                     input logic [W-1:0] fm, input int stall,
                     input bit junk);
    int           ref_d;
    logic [W-1:0] ed;
    logic         eb;
    logic         ee;
    ref_d = (int'(ta) - int'(tb) + (1 << W)) % (1 << W);
    ed    = W'(ref_d) ^ fm;
    eb    = (ta < tb);
    ee    = (fm != '0);

    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_out_valid", 32'(out_valid), 32'd0);
    a         = ta;
    b         = tb;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    @(posedge clk);
    #1;
    if (junk) begin
      a = ~ta;
      b = ~tb;
    end else begin
      in_valid = 1'b0;
    end
    for (int i = 0; i < W; i++) begin
      inj_fault = fm[i];
      chk("sub_out_valid", 32'(out_valid), 32'd0);
      chk("sub_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    inj_fault = 1'b0;
    chk("check_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("done_out_valid", 32'(out_valid), 32'd1);
    chk("done_diff", 32'(diff), 32'(ed));
    chk("done_borrow", 32'(borrow), 32'(eb));
    chk("done_chk_err", 32'(chk_err), 32'(ee));
    chk("done_in_ready", 32'(in_ready), 32'd0);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      #1;
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_diff", 32'(diff), 32'(ed));
      chk("stall_borrow", 32'(borrow), 32'(eb));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("post_out_valid", 32'(out_valid), 32'd0);
    chk("post_in_ready", 32'(in_ready), 32'd1);
    chk("post_diff_hold", 32'(diff), 32'(ed));
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    inj_fault = 1'b0;
    a         = '0;
    b         = '0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow", 32'(borrow), 32'd0);
    chk("rst_chk_err", 32'(chk_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run(4'd9, 4'd3, 4'h0, 0, 1'b0);
    run(4'd3, 4'd9, 4'h0, 0, 1'b0);
    run(4'd0, 4'd15, 4'h0, 1, 1'b0);
    run(4'd15, 4'd15, 4'h0, 0, 1'b0);
    run(4'd12, 4'd5, 4'h0, 3, 1'b1);
    run(4'd1, 4'd1, 4'h0, 0, 1'b0);
    run(4'd9, 4'd3, 4'h1, 0, 1'b0);
    run(4'd9, 4'd3, 4'h0, 0, 1'b0);

    // abort mid-SUB
    @(negedge clk);
    a        = 4'd9;
    b        = 4'd3;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_diff", 32'(diff), 32'd0);
    chk("abort_borrow", 32'(borrow), 32'd0);
    chk("abort_chk_err", 32'(chk_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("abort_quiet", 32'(out_valid), 32'd0);
    end
    run(4'd5, 4'd2, 4'h0, 0, 1'b0);

    for (int k = 0; k < 6; k++) begin
      run(W'($urandom), W'($urandom), W'($urandom_range(1, 15)),
          int'($urandom_range(0, 2)), 1'b0);
    end

    for (int i = 0; i < 256; i++) begin
      run(W'(i >> 4), W'(i & 15), 4'h0,
          int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sub4u_serial_chk.md
SUB4U_SERIAL_CHK -- requirements
Module: sub4u_serial_chk

Interface
REQ-001 SHALL have parameter W, default 4, giving operand and difference width in bits.
REQ-002 SHALL have input clk, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have input rst, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have input in_valid, 1 bit: operand pair offered.
REQ-005 SHALL have output in_ready, 1 bit: block accepts operands.
REQ-006 SHALL have input a, W bits: unsigned minuend.
REQ-007 SHALL have input b, W bits: unsigned subtrahend.
REQ-008 SHALL have input inj_fault, 1 bit: test-only fault injection, sampled in SUB.
REQ-009 SHALL have output out_valid, 1 bit: result available.
REQ-010 SHALL have input out_ready, 1 bit: consumer takes the result.
REQ-011 SHALL have output diff, W bits: (a - b) mod 2^W.
REQ-012 SHALL have output borrow, 1 bit: 1 when a < b.
REQ-013 SHALL have output chk_err, 1 bit: self-check mismatch for the current result.

Function
REQ-014 SHALL implement FSM states IDLE, SUB, CHECK, DONE.
REQ-015 in_ready SHALL equal (state == IDLE); out_valid SHALL equal (state == DONE); both SHALL be registered-state decodes with no combinational path from any input.
REQ-016 In IDLE, the in_valid && in_ready edge SHALL latch a and b, clear the borrow and bit counter, and enter SUB.
REQ-017 SUB SHALL process one bit per edge, LSB first: d_i = a_i ^ b_i ^ br; br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
REQ-018 SUB SHALL last exactly W edges, then enter CHECK.
REQ-019 When inj_fault = 1 on a SUB edge, the d_i stored on that edge SHALL be inverted; br_next SHALL be unaffected.
REQ-020 The CHECK edge SHALL compute the (W+1)-bit sum diff + b, compare it with {borrow, a}, register chk_err = mismatch, and enter DONE.
REQ-021 Latency: out_valid SHALL rise after the (W+1)th edge following the accept edge, i.e. 5 edges for W = 4.
REQ-022 In DONE, diff, borrow and chk_err SHALL hold stable until the out_valid && out_ready edge, which SHALL return the FSM to IDLE.
REQ-023 No new operands SHALL be accepted in SUB, CHECK or DONE; in_valid in those states SHALL be ignored.
REQ-024 A new operand pair SHALL be acceptable no earlier than the edge after the handshake that returns the FSM to IDLE; there is no back-to-back overlap.
REQ-025 diff, borrow and chk_err SHALL retain the last result while in IDLE, SUB and CHECK, and SHALL be updated only on the CHECK edge.
REQ-026 Fault-free operation SHALL always give chk_err = 0.

Reset
REQ-027 While rst = 1, state SHALL be IDLE, in_ready = 1, out_valid = 0, diff = 0, borrow = 0, chk_err = 0, and the bit counter and operand registers SHALL be 0.
REQ-028 rst asserted in any state, including mid-SUB or in DONE before the handshake, SHALL abort the operation immediately with no result emitted.
REQ-029 After rst deasserts, the next accepted pair SHALL compute correctly, independent of the aborted one.

Verification
REQ-030 a=9, b=3, out_ready=1 -> out_valid 5 edges after accept; diff=6, borrow=0, chk_err=0; in_ready=1 on the following cycle.
REQ-031 a=3, b=9 -> diff=10, borrow=1, chk_err=0; a=0, b=15 -> diff=1, borrow=1; a=15, b=15 -> diff=0, borrow=0.
REQ-032 a=12, b=5 with out_ready held 0 for 3 cycles after out_valid, and in_valid=1 with a=1, b=1 meanwhile -> diff=7, borrow=0 stable throughout, in_ready=0, second pair not accepted; pair accepted only after the handshake, giving diff=0.
REQ-033 a=9, b=3 with inj_fault=1 on the first SUB edge only -> diff=7, borrow=0, chk_err=1; next clean pair -> chk_err=0.
REQ-034 rst pulsed after the 2nd SUB edge of a=9, b=3 -> out_valid stays 0, in_ready=1, outputs 0; then a=5, b=2 -> diff=3, borrow=0.
REQ-035 Exhaustive sweep of all 256 (a, b) pairs with random out_ready stalls -> diff == (a - b) mod 16, borrow == (a < b), chk_err == 0 for every pair.
